// File: rtl/fifo_wr_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and
// the burst counter sizing helper.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Counter must hold MAX_BURST itself, not just MAX_BURST-1.
   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arb_if.sv
// Bundle of requester-side valid/ready/data and FIFO write-side signals
// shared between the arbiter (master) and its environment (slave).
interface fifo_wr_arb_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic                          fifo_full;
   logic                          fifo_ready;
   logic                          grant_active;
   logic [IDX_W-1:0]              grant_id;

   modport master (
      input  req_valid, req_data, fifo_full, fifo_ready,
      output req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id
   );

   modport slave (
      output req_valid, req_data, fifo_full, fifo_ready,
      input  req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id
   );

endinterface : fifo_wr_arb_if

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotate-priority encoder: first set request strictly after last_idx,
// wrapping modulo NUM_REQ, so last_idx itself is checked last.
module rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_idx,
   output logic               found,
   output logic [IDX_W-1:0]   next_idx
);

   logic [IDX_W-1:0] w_cand;

   // NOTE: every variable written here gets a default first, so no path
   // through the loop can leave a value held over and infer a latch.
   always_comb begin
      found    = 1'b0;
      next_idx = '0;
      w_cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
         if (!found && req[w_cand]) begin
            found    = 1'b1;
            next_idx = w_cand;
         end
      end
   end

endmodule : rr_pick

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one fifo_sync write port among NUM_REQ
// valid/ready sources, with bursts bounded to MAX_BURST beats per grant.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 16
) (
   input  logic          clk,
   input  logic          rst,
   fifo_wr_arb_if.master bus
);

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam int               CNT_W    = cnt_width(MAX_BURST);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_t            r_state, w_state_nxt;
   logic [IDX_W-1:0]      r_owner, w_owner_nxt;
   logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
   logic [DATA_WIDTH-1:0] w_beats [NUM_REQ];
   logic                  w_found;
   logic [IDX_W-1:0]      w_pick_idx;
   logic                  w_granted;
   logic                  w_can_write;
   logic                  w_accept;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_beats[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req      (bus.req_valid),
      .last_idx (r_owner),
      .found    (w_found),
      .next_idx (w_pick_idx)
   );

   // NOTE: sequential state uses non-blocking assignments only; the reset
   // is synchronous and active-low, so it lives inside the clocked branch.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_owner    <= LAST_IDX;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   // Writes are gated by rst too, so nothing lands during a reset cycle.
   assign w_granted   = (r_state == GRANT);
   assign w_can_write = w_granted & rst & bus.fifo_ready & ~bus.fifo_full;
   assign w_accept    = w_can_write & bus.req_valid[r_owner];

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_beat_cnt_nxt = r_beat_cnt;
      case (r_state)
         IDLE: begin
            if (bus.fifo_ready && w_found) begin
               w_state_nxt    = GRANT;
               w_owner_nxt    = w_pick_idx;
               w_beat_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (w_accept) begin
               w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
               if (r_beat_cnt == CNT_LAST) w_state_nxt = IDLE;
            end else if (!bus.req_valid[r_owner]) begin
               // Dropping valid forfeits the grant even while stalled.
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_owner == IDX_W'(i)) bus.req_ready[i] = w_can_write;
      end
   end

   assign bus.fifo_wr_en   = w_accept;
   assign bus.fifo_wr_data = w_accept ? w_beats[r_owner] : '0;
   assign bus.grant_active = w_granted;
   assign bus.grant_id     = r_owner;

endmodule : fifo_wr_arb

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: per-requester source queues and a
// write-order scoreboard, plus grant/burst/gap logs checked per scenario.
module tb_fifo_wr_arb;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 16;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   fifo_wr_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   logic [7:0] src_q [NR][$];
   exp_t exp_q [$];
   int   acc_cnt [NR] = '{default: 0};
   int   grant_log [$];
   int   run_len [$];
   int   gap_log [$];
   int   cyc = 0;
   int   last_wr_cyc = 0;
   int   last_wr_id = -1;
   logic prev_ga = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int id, input int base, input int n);
      for (int j = 0; j < n; j++) src_q[id].push_back(8'(base + j));
   endtask

   task automatic expect_beats(input int id, input int base, input int n);
      for (int j = 0; j < n; j++) exp_q.push_back('{id, 8'(base + j)});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.grant_active); i++) step();
      check(tag, exp_q.size(), 0);
      step();
   endtask

   task automatic check_log(input string tag, input int q[$], input int base, input int exp_vals[$]);
      check({tag, "_n"}, q.size() - base, exp_vals.size());
      for (int k = 0; k < exp_vals.size() && base + k < q.size(); k++)
         check(tag, q[base + k], exp_vals[k]);
   endtask

   // Requester drivers: present the next unaccepted byte of each source.
   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > acc_cnt[i]) begin
               bus.req_valid[i]         = 1'b1;
               bus.req_data[i*DW +: DW] = src_q[i][acc_cnt[i]];
            end else begin
               bus.req_valid[i]         = 1'b0;
               bus.req_data[i*DW +: DW] = '0;
            end
         end
      end
   end

   // Monitor: sampled mid-cycle, opposite the active edge.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (bus.grant_active && !prev_ga) begin
         grant_log.push_back(int'(bus.grant_id));
         run_len.push_back(0);
      end
      prev_ga = bus.grant_active;
      if (bus.fifo_wr_en) begin
         check("wr_gate", {29'd0, rst, bus.fifo_ready, bus.fifo_full}, 32'b110);
         if (exp_q.size() == 0) begin
            check("wr_with_empty_sb", bus.fifo_wr_en, 0);
         end else begin
            e = exp_q.pop_front();
            check("wr_data", bus.fifo_wr_data, e.data);
            check("wr_id", bus.grant_id, e.id);
         end
         if (int'(bus.grant_id) != last_wr_id) gap_log.push_back(cyc - last_wr_cyc);
         last_wr_cyc = cyc;
         last_wr_id  = int'(bus.grant_id);
         if (run_len.size() > 0) run_len[run_len.size()-1] += 1;
      end
      if (|bus.req_ready) check("ready_onehot", $countones(bus.req_ready), 1);
      for (int i = 0; i < NR; i++)
         if (bus.req_valid[i] && bus.req_ready[i]) acc_cnt[i]++;
   end

   initial begin
      int gb, rb, pb;
      rst             = 1'b0;
      bus.fifo_full   = 1'b0;
      bus.fifo_ready  = 1'b1;

      // Reset state
      step();
      step();
      @(negedge clk);
      check("rst_grant_active", bus.grant_active, 0);
      check("rst_grant_id", bus.grant_id, NR - 1);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_wr_en", bus.fifo_wr_en, 0);
      check("rst_wr_data", bus.fifo_wr_data, 0);
      rst = 1'b1;
      step();

      // Single requester 2, five beats
      gb = grant_log.size(); rb = run_len.size();
      load(2, 8'hA0, 5);
      expect_beats(2, 8'hA0, 5);
      @(negedge clk);
      check("t1_idle_c0", bus.grant_active, 0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("t1_wr_en", bus.fifo_wr_en, 1);
         if (k == 1) check("t1_grant_id", bus.grant_id, 2);
      end
      @(negedge clk);
      check("t1_no_wr_after", bus.fifo_wr_en, 0);
      @(negedge clk);
      check("t1_released", bus.grant_active, 0);
      wait_drain("t1_drain");
      check_log("t1_grants", grant_log, gb, '{2});
      check_log("t1_runs", run_len, rb, '{5});

      // Full contention, bounded bursts
      do_reset();
      gb = grant_log.size(); rb = run_len.size(); pb = gap_log.size();
      load(0, 0, 20); load(1, 32, 16); load(2, 64, 16); load(3, 96, 16);
      expect_beats(0, 0, 16); expect_beats(1, 32, 16);
      expect_beats(2, 64, 16); expect_beats(3, 96, 16);
      expect_beats(0, 16, 4);
      wait_drain("t2_drain");
      check_log("t2_grants", grant_log, gb, '{0, 1, 2, 3, 0});
      check_log("t2_runs", run_len, rb, '{16, 16, 16, 16, 4});
      check_log("t2_gaps", gap_log, pb + 1, '{2, 2, 2, 2});

      // FIFO full mid-burst: stall holds owner and count
      gb = grant_log.size(); rb = run_len.size();
      load(1, 8'h80, 18);
      expect_beats(1, 8'h80, 18);
      repeat (4) step();
      bus.fifo_full = 1'b1;
      @(negedge clk);
      check("t3_full_wr_en", bus.fifo_wr_en, 0);
      check("t3_full_ready", bus.req_ready, 0);
      check("t3_full_held", bus.grant_active, 1);
      check("t3_full_owner", bus.grant_id, 1);
      step();
      step();
      @(negedge clk);
      check("t3_still_held", {31'd0, bus.grant_active}, 1);
      step();
      bus.fifo_full = 1'b0;
      @(negedge clk);
      check("t3_resume_wr_en", bus.fifo_wr_en, 1);
      wait_drain("t3_drain");
      check_log("t3_grants", grant_log, gb, '{1, 1});
      check_log("t3_runs", run_len, rb, '{16, 2});

      // FIFO not ready: no grant until it rises, then requester 0 first
      bus.fifo_ready = 1'b0;
      do_reset();
      gb = grant_log.size();
      load(0, 8'h40, 2); load(2, 8'h42, 2);
      expect_beats(0, 8'h40, 2); expect_beats(2, 8'h42, 2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t4_no_grant", bus.grant_active, 0);
         check("t4_no_wr", bus.fifo_wr_en, 0);
         step();
      end
      bus.fifo_ready = 1'b1;
      @(negedge clk);
      check("t4_arb_cycle", bus.grant_active, 0);
      @(negedge clk);
      check("t4_first_id", bus.grant_id, 0);
      check("t4_first_wr", bus.fifo_wr_en, 1);
      wait_drain("t4_drain");
      check_log("t4_grants", grant_log, gb, '{0, 2});

      // Reset at beat 7 of a requester 1 burst
      do_reset();
      gb = grant_log.size(); rb = run_len.size();
      load(1, 8'hC0, 12);
      expect_beats(1, 8'hC0, 6);
      repeat (7) step();
      rst = 1'b0;
      @(negedge clk);
      check("t5_rst_no_wr", bus.fifo_wr_en, 0);
      check("t5_rst_no_ready", bus.req_ready, 0);
      step();
      @(negedge clk);
      check("t5_grant_active", bus.grant_active, 0);
      check("t5_grant_id", bus.grant_id, NR - 1);
      check("t5_req_ready", bus.req_ready, 0);
      check("t5_wr_en", bus.fifo_wr_en, 0);
      check("t5_wr_data", bus.fifo_wr_data, 0);
      load(0, 8'h50, 3);
      expect_beats(0, 8'h50, 3);
      expect_beats(1, 8'hC6, 6);
      step();
      rst = 1'b1;
      wait_drain("t5_drain");
      check_log("t5_grants", grant_log, gb, '{1, 0, 1});
      check_log("t5_runs", run_len, rb, '{6, 3, 6});

      // Owner drops valid after 3 beats with requester 3 waiting
      do_reset();
      gb = grant_log.size(); pb = gap_log.size();
      load(0, 8'h60, 3); load(3, 8'h70, 3);
      expect_beats(0, 8'h60, 3); expect_beats(3, 8'h70, 3);
      wait_drain("t6_drain");
      check_log("t6_grants", grant_log, gb, '{0, 3});
      check_log("t6_gaps", gap_log, pb + 1, '{3});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fifo_wr_arb

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter that shares a single `fifo_sync` write port among `NUM_REQ` valid/ready requesters (e.g. UART TX byte sources: command responder, debug dump, loopback). It grants one requester at a time for a bounded burst of up to `MAX_BURST` beats. It gates all writes on FIFO `ready` (post-init) and `full`, so no write is ever issued into a full or uninitialised FIFO. It sits directly upstream of `fifo_sync`; the skid buffer remains on the read side.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, width of one beat
- `MAX_BURST`, 16, max consecutive beats per grant (≥1)

- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous reset, active-low (asserted when 0, sampled on rising `clk`)
- `req_valid`  in  NUM_REQ  per-requester beat valid
- `req_data`  in  NUM_REQ*DATA_WIDTH  flattened beats; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high
- `fifo_wr_en`  out  1  FIFO write strobe
- `fifo_wr_data`  out  DATA_WIDTH  FIFO write data
- `fifo_full`  in  1  FIFO full flag
- `fifo_ready`  in  1  FIFO initialised and writable
- `grant_active`  out  1  a requester currently owns the port
- `grant_id`  out  $clog2(NUM_REQ)  current/last owner index

## Operation
- States: IDLE, GRANT.
- IDLE: if `fifo_ready` and any `req_valid`, pick the first set bit searching from `last_owner+1` (mod NUM_REQ) upward. Register owner and `last_owner`, clear `beat_cnt`, go to GRANT. Otherwise stay in IDLE.
- GRANT: `req_ready[owner] = fifo_ready & ~fifo_full`. All other ready bits are 0.
- Beat accept = `req_valid[owner] & req_ready[owner]`. On accept: `fifo_wr_en=1`, `fifo_wr_data=req_data[owner]`, `beat_cnt++`.
- Release to IDLE when either:
  - an accept takes `beat_cnt` to `MAX_BURST`; or
  - `req_valid[owner]==0` in a GRANT cycle (no beat that cycle).
- `fifo_full` or `~fifo_ready` in GRANT: stall. Grant held, counter held, no release, no write.
- Requester contract: while `valid & ~ready`, hold data stable and keep `valid` high. Dropping `valid` forfeits the grant.
- `beat_cnt` width is `$clog2(MAX_BURST+1)` and never wraps; release occurs exactly at `MAX_BURST`.

## Timing
- Reset (`rst==0` at an edge), taking effect next cycle:
  - state=IDLE, `beat_cnt=0`, `last_owner=NUM_REQ-1` (so requester 0 has first priority)
  - `grant_active=0`, `grant_id=NUM_REQ-1`
  - `req_ready=0`, `fifo_wr_en=0`, `fifo_wr_data=0`
- Reset mid-burst: same as above. No write occurs in any cycle where `rst==0`; the partial burst is abandoned.
- `fifo_wr_en`, `fifo_wr_data` and `req_ready` are combinational from registered owner/state plus `fifo_full`/`fifo_ready`/`req_valid`. There is no registered output stage, so a write never lands after `full` rises.
- Latency, request in IDLE to first write: valid seen in cycle 0, GRANT in cycle 1, first `fifo_wr_en` in cycle 1 (FIFO permitting).
- Handover: the release edge is followed by one IDLE arbitration cycle, then the next owner writes. Sustained throughput is MAX_BURST beats per MAX_BURST+1 cycles under contention.
- `grant_active=1` exactly while state==GRANT.

## Structure
- Package `fifo_arb_pkg`: `arb_state_t` enum (IDLE, GRANT) and a helper function computing the counter width.
- Sub-module `rr_pick`: purely combinational rotate-priority encoder.
  - Inputs: request vector, last index.
  - Outputs: `found`, `next_idx`.
  - Instantiated once in IDLE arbitration.
- Remaining logic: owner register, `beat_cnt`, FSM and output mux in `fifo_wr_arb`.

## Test plan
- Reset then single requester 2 streams 5 beats 0xA0..0xA4:
  - grant in the cycle after valid
  - five consecutive `fifo_wr_en` with data 0xA0..0xA4
  - release to IDLE after valid drops
- All 4 requesters valid continuously, MAX_BURST=16:
  - grants in order 0,1,2,3,0
  - exactly 16 writes per grant
  - one idle cycle between grants
- Fill FIFO to `full` mid-burst:
  - `fifo_wr_en` and `req_ready` drop the same cycle
  - owner and `beat_cnt` held
  - writes resume on `full` deassert with no lost or duplicated byte
- `fifo_ready=0` while requests pending: no grant, no write. On `fifo_ready` rise, requester 0 wins first.
- Reset asserted at beat 7 of a burst from requester 1:
  - all outputs 0 next cycle
  - after release, requester 0 is granted before requester 1
- Owner drops valid after 3 beats while requester 3 is waiting: release, then requester 3 granted two cycles later. Scoreboard checks the FIFO contents order.
